bram_uart_tx: RTL and testbench

BRAM_UART_TX -- requirements
Module: bram_uart_tx

---
 rtl/bram_uart_tx.sv | 147 ++++++++++++++
 tb/tb_bram_uart_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_uart_tx.sv
// Streams a range of BRAM bytes out of an 8N1 UART transmitter, one byte per frame,
// from start_addr up to LAST_ADDR, with a fixed idle gap between frames.
module bram_uart_tx #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned DIV_BIT      = CLK_FREQ / BAUD_RATE,
  parameter int unsigned LAST_ADDR    = 16383,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] start_addr,
  input  logic [7:0]  dout,
  output logic        ena_imtx,
  output logic        wea_imtx,
  output logic [13:0] addr_imtx,
  output logic        TxD,
  output logic        busy,
  output logic        ImTxComplete
);

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned FRAME_W = 10;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned BAUD_W  = (DIV_BIT > 1) ? $clog2(DIV_BIT) : 1;
  localparam int unsigned WAIT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV_BIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    NEXT
  } state_t;

  state_t              state, state_n;
  logic [FRAME_W-1:0]  shift, shift_n;
  logic [BIT_W-1:0]    bit_cnt, bit_n;
  logic [BAUD_W-1:0]   baud_cnt, baud_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                complete_n;
  logic                txd_n;
  logic                busy_n;
  logic                ena_n;

  // The BRAM is read-only from this block.
  assign wea_imtx = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_n      = bit_cnt;
    baud_n     = baud_cnt;
    wait_n     = wait_cnt;
    addr_n     = addr_imtx;
    complete_n = ImTxComplete;

    case (state)
      IDLE: begin
        if (start) begin
          addr_n     = start_addr;
          complete_n = 1'b0;
          wait_n     = '0;
          state_n    = FETCH;
        end
      end
      FETCH: begin
        if (wait_cnt == WAIT_LAST) begin
          wait_n  = '0;
          state_n = LOAD;
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      LOAD: begin
        shift_n = {1'b1, dout, 1'b0};
        bit_n   = '0;
        baud_n  = '0;
        state_n = SEND;
      end
      SEND: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          shift_n = {1'b1, shift[FRAME_W-1:1]};
          bit_n   = bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_LAST) state_n = NEXT;
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      NEXT: begin
        // An out-of-range start address still ends here instead of wrapping.
        if (addr_imtx >= ADDR_LAST) begin
          complete_n = 1'b1;
          state_n    = IDLE;
        end else begin
          addr_n  = addr_imtx + ADDR_W'(1);
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state.
    txd_n  = (state_n == SEND) ? shift_n[0] : 1'b1;
    busy_n = (state_n != IDLE);
    ena_n  = (state_n == FETCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift        <= '0;
      bit_cnt      <= '0;
      baud_cnt     <= '0;
      wait_cnt     <= '0;
      addr_imtx    <= '0;
      ImTxComplete <= 1'b0;
      TxD          <= 1'b1;
      busy         <= 1'b0;
      ena_imtx     <= 1'b0;
    end else begin
      shift        <= shift_n;
      bit_cnt      <= bit_n;
      baud_cnt     <= baud_n;
      wait_cnt     <= wait_n;
      addr_imtx    <= addr_n;
      ImTxComplete <= complete_n;
      TxD          <= txd_n;
      busy         <= busy_n;
      ena_imtx     <= ena_n;
    end
  end

endmodule

// File: tb/tb_bram_uart_tx.sv
// Bench for bram_uart_tx: a latency-2 BRAM model feeds the DUT, and every cycle of a dump
// is compared against a waveform built from the frame/gap timing rules.
module tb_bram_uart_tx;

  localparam int unsigned CLK_FREQ  = 1000;
  localparam int unsigned BAUD_RATE = 100;
  localparam int unsigned DIV       = CLK_FREQ / BAUD_RATE;
  localparam int unsigned LAST      = 5;
  localparam int unsigned RL        = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] start_addr;
  logic [7:0]  dout;
  logic        ena_imtx;
  logic        wea_imtx;
  logic [13:0] addr_imtx;
  logic        TxD;
  logic        busy;
  logic        ImTxComplete;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:16383];
  logic [7:0]  rd1;
  logic [17:0] exp_q [$];

  bram_uart_tx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE),
    .DIV_BIT     (DIV),
    .LAST_ADDR   (LAST),
    .READ_LATENCY(RL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_addr  (start_addr),
    .dout        (dout),
    .ena_imtx    (ena_imtx),
    .wea_imtx    (wea_imtx),
    .addr_imtx   (addr_imtx),
    .TxD         (TxD),
    .busy        (busy),
    .ImTxComplete(ImTxComplete)
  );

  always #5 clk = ~clk;

  // Two-stage read pipeline: data appears two clocks after the address.
  always @(posedge clk) begin
    if (ena_imtx) rd1 <= mem[addr_imtx];
    dout <= rd1;
  end

  always @(negedge clk) begin
    total++;
    if (wea_imtx !== 1'b0) begin
      bad++;
      $display("FAIL wea_imtx at %0t: got %b want 0", $time, wea_imtx);
    end
  end

  function automatic logic [17:0] pack(input logic t, input logic b, input logic e,
                                       input logic c, input int a);
    return {t, b, e, c, 14'(a)};
  endfunction

  // Expected per-cycle {TxD, busy, ena, complete, addr} from the cycle after start is taken.
  function automatic void build_expect(input int sa);
    int last_a;
    int frame;
    exp_q.delete();
    last_a = (sa > int'(LAST)) ? sa : int'(LAST);
    for (int a = sa; a <= last_a; a++) begin
      if (a != sa) exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, a - 1));
      repeat (RL) exp_q.push_back(pack(1'b1, 1'b1, 1'b1, 1'b0, a));
      exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, a));
      frame = 512 + 2 * int'(mem[14'(a)]);
      for (int b = 0; b < 10; b++)
        repeat (DIV) exp_q.push_back(pack(1'((frame >> b) & 1), 1'b1, 1'b0, 1'b0, a));
    end
    exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, last_a));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b1, last_a));
  endfunction

  task automatic hard_reset();
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start(input int sa);
    start      = 1'b1;
    start_addr = 14'(sa);
    @(negedge clk);
    start = 1'b0;
  endtask

  // kind 0: plain dump, 1: start pulse (addr 0) at cycle 'at', 2: reset at cycle 'at'.
  task automatic run_check(input string name, input int kind, input int at);
    logic [17:0] act;
    for (int i = 0; i < exp_q.size(); i++) begin
      act = {TxD, busy, ena_imtx, ImTxComplete, addr_imtx};
      total++;
      if (act !== exp_q[i]) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h want %h", name, i, act, exp_q[i]);
        hard_reset();
        return;
      end
      if (kind == 1 && i == at) begin
        start      = 1'b1;
        start_addr = 14'd0;
      end
      if (kind == 1 && i == at + 1) start = 1'b0;
      if (kind == 2 && i == at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        act = {TxD, busy, ena_imtx, ImTxComplete, addr_imtx};
        total++;
        if (act !== pack(1'b1, 1'b0, 1'b0, 1'b0, 0)) begin
          bad++;
          $display("FAIL %s after reset: got %h want %h", name, act, pack(1'b1, 1'b0, 1'b0, 1'b0, 0));
        end
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [18:0] act;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    repeat (3) @(negedge clk);
    act = {TxD, busy, ena_imtx, wea_imtx, ImTxComplete, addr_imtx};
    total++;
    if (act !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0}) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", act, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    mem[5] = 8'hA5;
    build_expect(5);
    do_start(5);
    run_check("single_byte", 0, 0);
  endtask

  task automatic test_multi_byte();
    mem[3] = 8'h00;
    mem[4] = 8'hFF;
    mem[5] = 8'h3C;
    build_expect(3);
    do_start(3);
    run_check("multi_byte", 0, 0);
  endtask

  task automatic test_start_while_busy();
    for (int a = 1; a <= int'(LAST); a++) mem[a] = 8'($urandom);
    build_expect(1);
    do_start(1);
    // Lands mid-way through the second frame's data bits.
    run_check("start_while_busy", 1, (RL + 1 + 10 * DIV) + (RL + 2) + 3 * DIV + 2);
  endtask

  task automatic test_reset_mid_frame();
    mem[4] = 8'($urandom) & 8'hEF;
    mem[5] = 8'($urandom);
    build_expect(4);
    do_start(4);
    run_check("reset_mid_frame", 2, RL + 1 + 5 * DIV + 3);
    build_expect(4);
    do_start(4);
    run_check("after_reset_dump", 0, 0);
  endtask

  task automatic test_restart();
    total++;
    if (ImTxComplete !== 1'b1) begin
      bad++;
      $display("FAIL restart_precond: got complete=%b want 1", ImTxComplete);
    end
    for (int a = 2; a <= int'(LAST); a++) mem[a] = 8'($urandom);
    build_expect(2);
    do_start(2);
    run_check("restart", 0, 0);
  endtask

  task automatic test_random();
    int sa;
    int last_a;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 2) == 0) sa = int'($urandom_range(LAST + 1, 16383));
      else                           sa = int'($urandom_range(0, LAST));
      last_a = (sa > int'(LAST)) ? sa : int'(LAST);
      for (int a = sa; a <= last_a; a++) mem[14'(a)] = 8'($urandom);
      build_expect(sa);
      do_start(sa);
      run_check($sformatf("random_%0d_sa%0d", n, sa), 0, 0);
    end
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) mem[a] = 8'h00;
    rd1 = 8'h00;
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_start_while_busy();
    test_reset_mid_frame();
    test_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
